// File: rtl/entity_frame_writer_pkg.sv
// Shared constants and types for the entity frame writer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: slot indices, entity field offsets, reset words, FSM states,
// and the vertical timing points that define vblank.
package entity_frame_writer_pkg;

  // Vertical timing: first blanking line and lines per frame.
  localparam logic [9:0] V_VISIBLE = 10'd480;
  localparam logic [9:0] V_TOTAL   = 10'd525;

  // Entity word layout: {ID[13:10], orient[9:8], tile[7:0]}.
  localparam int ENT_W        = 14;
  localparam int ARR_W        = 18;
  localparam int ENT_ID_LSB   = 10;
  localparam int ENT_ORI_LSB  = 8;
  localparam int ENT_TILE_LSB = 0;

  localparam logic [3:0] UNUSED_ID = 4'hF;

  // Reset words: channel marked unused, every other field zero.
  localparam logic [ENT_W-1:0] RST_WORD14 = {UNUSED_ID, 10'd0};
  localparam logic [ARR_W-1:0] RST_WORD18 = {UNUSED_ID, 14'd0};

  typedef enum logic [2:0] {
    SLOT_E1  = 3'd0,
    SLOT_E4  = 3'd1,
    SLOT_E5  = 3'd2,
    SLOT_E6  = 3'd3,
    SLOT_E7A = 3'd4,
    SLOT_E8F = 3'd5
  } slot_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_HOLD = 2'd1,
    ST_COMMIT    = 2'd2
  } state_t;

  // Slots 6 and 7 have no backing storage.
  function automatic logic is_legal_slot(input logic [2:0] slot);
    return slot <= SLOT_E8F;
  endfunction

endpackage

// File: rtl/entity_frame_writer_vblank_detect.sv
// Samples the raster counters and flags vblank start and the vblank window.
// Latency: one cycle from counter values to vblank_start/in_vblank.
// Backpressure: none; free-running sampler.
//
// Ports: clk, reset (sync, active-high), counter_H/counter_V (10b raster
// counters), vblank_start (high while sampled V==V_VISIBLE && H==0),
// in_vblank (high while sampled V is inside the blanking lines).
module entity_frame_writer_vblank_detect
  import entity_frame_writer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] counter_H,
  input  logic [9:0] counter_V,
  output logic       vblank_start,
  output logic       in_vblank
);

  logic [9:0] h_q;
  logic [9:0] v_q;

  // This register is the single cycle of detection latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= counter_H;
      v_q <= counter_V;
    end
  end

  assign vblank_start = (v_q == V_VISIBLE) && (h_q == 10'd0);
  assign in_vblank    = (v_q >= V_VISIBLE) && (v_q < V_TOTAL);

endmodule

// File: rtl/entity_frame_writer.sv
// Double-buffers entity words: writes land in shadow, vblank commits all at once.
// Latency: write visible in shadow next edge; active outputs update 2 clks after vblank-start sample.
// Backpressure: wr_ready drops only during the single COMMIT cycle.
//
// Ports: clk, reset (sync, active-high); counter_H/counter_V raster counters;
// wr_valid/wr_ready/wr_slot/wr_data write port; batch_hold defers the commit;
// entity_1/4/5/6/8_Flip (14b) and entity_7_Array (18b) active words;
// commit_pulse, wr_err pulses; frames_dropped saturating skipped-commit count.
module entity_frame_writer
  import entity_frame_writer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       counter_H,
  input  logic [9:0]       counter_V,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [2:0]       wr_slot,
  input  logic [ARR_W-1:0] wr_data,
  input  logic             batch_hold,
  output logic [ENT_W-1:0] entity_1,
  output logic [ENT_W-1:0] entity_4,
  output logic [ENT_W-1:0] entity_5,
  output logic [ENT_W-1:0] entity_6,
  output logic [ARR_W-1:0] entity_7_Array,
  output logic [ENT_W-1:0] entity_8_Flip,
  output logic             commit_pulse,
  output logic             wr_err,
  output logic [7:0]       frames_dropped
);

  state_t state;

  logic vblank_start;
  logic in_vblank;

  logic [ENT_W-1:0] sh_e1;
  logic [ENT_W-1:0] sh_e4;
  logic [ENT_W-1:0] sh_e5;
  logic [ENT_W-1:0] sh_e6;
  logic [ARR_W-1:0] sh_e7a;
  logic [ENT_W-1:0] sh_e8f;

  logic wr_fire;

  entity_frame_writer_vblank_detect u_vblank_detect (
    .clk          (clk),
    .reset        (reset),
    .counter_H    (counter_H),
    .counter_V    (counter_V),
    .vblank_start (vblank_start),
    .in_vblank    (in_vblank)
  );

  // Refusing writes in COMMIT keeps the copied snapshot consistent; the
  // held write simply lands in shadow one cycle later for the next frame.
  assign wr_ready = (state != ST_COMMIT);
  assign wr_fire  = wr_valid && wr_ready;

  // Shadow bank. Illegal slots are still accepted so the writer never stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_e1  <= RST_WORD14;
      sh_e4  <= RST_WORD14;
      sh_e5  <= RST_WORD14;
      sh_e6  <= RST_WORD14;
      sh_e7a <= RST_WORD18;
      sh_e8f <= RST_WORD14;
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_fire && !is_legal_slot(wr_slot);
      if (wr_fire) begin
        case (slot_t'(wr_slot))
          SLOT_E1:  sh_e1  <= wr_data[ENT_W-1:0];
          SLOT_E4:  sh_e4  <= wr_data[ENT_W-1:0];
          SLOT_E5:  sh_e5  <= wr_data[ENT_W-1:0];
          SLOT_E6:  sh_e6  <= wr_data[ENT_W-1:0];
          SLOT_E7A: sh_e7a <= wr_data;
          SLOT_E8F: sh_e8f <= wr_data[ENT_W-1:0];
          default: ;
        endcase
      end
    end
  end

  // Commit FSM and active bank. commit_pulse is registered alongside the
  // transition into COMMIT so it is high exactly during the COMMIT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      commit_pulse   <= 1'b0;
      frames_dropped <= 8'd0;
      entity_1       <= RST_WORD14;
      entity_4       <= RST_WORD14;
      entity_5       <= RST_WORD14;
      entity_6       <= RST_WORD14;
      entity_7_Array <= RST_WORD18;
      entity_8_Flip  <= RST_WORD14;
    end else begin
      commit_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (vblank_start) begin
            if (!batch_hold) begin
              state        <= ST_COMMIT;
              commit_pulse <= 1'b1;
            end else begin
              state <= ST_WAIT_HOLD;
            end
          end
        end
        ST_WAIT_HOLD: begin
          if (!in_vblank) begin
            // Next frame has begun without a commit: this frame is lost.
            state <= ST_IDLE;
            if (frames_dropped != 8'hFF) begin
              frames_dropped <= frames_dropped + 8'd1;
            end
          end else if (!batch_hold) begin
            state        <= ST_COMMIT;
            commit_pulse <= 1'b1;
          end
        end
        ST_COMMIT: begin
          entity_1       <= sh_e1;
          entity_4       <= sh_e4;
          entity_5       <= sh_e5;
          entity_6       <= sh_e6;
          entity_7_Array <= sh_e7a;
          entity_8_Flip  <= sh_e8f;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_entity_frame_writer.sv
// Randomized bench for entity_frame_writer with a frame-level reference model.
// Latency: n/a.
// Backpressure: writer holds a request until the model says it was taken.
module tb_entity_frame_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  counter_H;
  logic [9:0]  counter_V;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_slot;
  logic [17:0] wr_data;
  logic        batch_hold;
  logic [13:0] entity_1, entity_4, entity_5, entity_6, entity_8_Flip;
  logic [17:0] entity_7_Array;
  logic        commit_pulse;
  logic        wr_err;
  logic [7:0]  frames_dropped;

  always #5 clk = ~clk;

  entity_frame_writer dut (
    .clk            (clk),
    .reset          (reset),
    .counter_H      (counter_H),
    .counter_V      (counter_V),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_slot        (wr_slot),
    .wr_data        (wr_data),
    .batch_hold     (batch_hold),
    .entity_1       (entity_1),
    .entity_4       (entity_4),
    .entity_5       (entity_5),
    .entity_6       (entity_6),
    .entity_7_Array (entity_7_Array),
    .entity_8_Flip  (entity_8_Flip),
    .commit_pulse   (commit_pulse),
    .wr_err         (wr_err),
    .frames_dropped (frames_dropped)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Scene-level view: a shadow scene, the scene shown, whether this frame
  // still owes a commit, and whether the next cycle is the copy cycle.
  int unsigned m_shadow[6];
  int unsigned m_active[6];
  bit          m_owed;
  bit          m_copy_next;
  bit          m_err;
  bit          m_acc;
  int          m_drop;
  int          m_prev_v, m_prev_h;

  function automatic int unsigned reset_word(input int s);
    return (s == 4) ? 32'h3C000 : 32'h3C00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_shadow[i] = reset_word(i);
      m_active[i] = reset_word(i);
    end
    m_owed = 0; m_copy_next = 0; m_err = 0; m_acc = 0; m_drop = 0;
    m_prev_v = 0; m_prev_h = 0;
  endtask

  task automatic model_edge();
    bit vb_start, vb_in, commit_soon;
    if (reset) begin
      model_reset();
    end else begin
      vb_start    = (m_prev_v == 480) && (m_prev_h == 0);
      vb_in       = (m_prev_v >= 480) && (m_prev_v < 525);
      m_acc       = wr_valid && !m_copy_next;
      commit_soon = 0;
      if (m_copy_next) begin
        for (int i = 0; i < 6; i++) m_active[i] = m_shadow[i];
      end else if (m_owed) begin
        if (!vb_in) begin
          m_owed = 0;
          if (m_drop < 255) m_drop++;
        end else if (!batch_hold) begin
          m_owed = 0;
          commit_soon = 1;
        end
      end else if (vb_start) begin
        if (batch_hold) m_owed = 1;
        else commit_soon = 1;
      end
      m_err = m_acc && (wr_slot > 3'd5);
      if (m_acc && wr_slot <= 3'd5)
        m_shadow[wr_slot] = (wr_slot == 3'd4) ? 32'(wr_data) : 32'(wr_data[13:0]);
      m_copy_next = commit_soon;
      m_prev_v = int'(counter_V);
      m_prev_h = int'(counter_H);
    end
  endtask

  task automatic check_all();
    chk("entity_1",       32'(entity_1),       m_active[0]);
    chk("entity_4",       32'(entity_4),       m_active[1]);
    chk("entity_5",       32'(entity_5),       m_active[2]);
    chk("entity_6",       32'(entity_6),       m_active[3]);
    chk("entity_7_Array", 32'(entity_7_Array), m_active[4]);
    chk("entity_8_Flip",  32'(entity_8_Flip),  m_active[5]);
    chk("commit_pulse",   32'(commit_pulse),   32'(m_copy_next));
    chk("wr_err",         32'(wr_err),         32'(m_err));
    chk("frames_dropped", 32'(frames_dropped), 32'(m_drop));
    chk("wr_ready",       32'(wr_ready),       32'(!m_copy_next));
  endtask

  // ---------------- stimulus ----------------
  bit          w_pending = 0;
  logic [2:0]  w_slot;
  logic [17:0] w_data;
  int          wr_prob = 0;
  bit          hold_random = 0;

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic step(input int v, input int h);
    counter_V = 10'(v);
    counter_H = 10'(h);
    if (!w_pending && wr_prob > 0 && $urandom_range(0, 99) < wr_prob) begin
      w_pending = 1;
      w_slot    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      w_data    = 18'($urandom);
    end
    wr_valid = w_pending;
    wr_slot  = w_pending ? w_slot : 3'($urandom);
    wr_data  = w_pending ? w_data : 18'($urandom);
    if (hold_random) batch_hold = 1'($urandom);
    tick();
    if (m_acc) w_pending = 0;
  endtask

  task automatic write(input int v, input logic [2:0] s, input logic [17:0] d);
    w_pending = 1; w_slot = s; w_data = d;
    step(v, 1);
  endtask

  task automatic do_reset(input int n);
    reset = 1; wr_valid = 0; w_pending = 0;
    for (int i = 0; i < n; i++) step(0, 0);
    reset = 0;
  endtask

  // mode 0: no hold, 1: hold across vblank start released at V=490,
  // 2: hold until the next frame's V=10, 3: random hold every cycle.
  task automatic run_frame(input int mode);
    hold_random = (mode == 3);
    if (mode != 3) batch_hold = 0;
    for (int i = 0; i < 5; i++) step(100 + i * 70, i + 1);
    if (mode == 1 || mode == 2) batch_hold = 1;
    step(470, 3);
    step(479, 799);
    step(480, 0);
    for (int h = 1; h < 5; h++) step(480, h);
    if (mode == 1) batch_hold = 0;
    for (int h = 0; h < 3; h++) step(490, h);
    step(500, 0);
    step(524, 0);
    step(0, 0);
    step(5, 0);
    if (mode == 2) batch_hold = 0;
    step(10, 0);
    hold_random = 0;
  endtask

  task automatic vblank_commit();
    step(479, 5);
    step(480, 0);
    step(480, 1);
    step(480, 2);
  endtask

  initial begin
    model_reset();
    reset = 1; counter_H = 0; counter_V = 0; wr_valid = 0; wr_slot = 0;
    wr_data = 0; batch_hold = 0;

    // Reset values.
    do_reset(2);
    chk("rst_entity_1", 32'(entity_1), 32'h3C00);
    chk("rst_entity_7", 32'(entity_7_Array), 32'h3C000);
    chk("rst_dropped", 32'(frames_dropped), 32'd0);
    chk("rst_ready", 32'(wr_ready), 32'd1);

    // Basic commit: output frozen until vblank, then updated two clocks later.
    write(100, 3'd0, 18'h1234);
    step(479, 799);
    chk("basic_pre", 32'(entity_1), 32'h3C00);
    step(480, 0);
    step(480, 1);
    chk("basic_pulse", 32'(commit_pulse), 32'd1);
    chk("basic_mid", 32'(entity_1), 32'h3C00);
    step(480, 2);
    chk("basic_post", 32'(entity_1), 32'h1234);
    chk("basic_pulse_end", 32'(commit_pulse), 32'd0);
    step(500, 0);
    step(0, 0);

    // Collision with the COMMIT cycle.
    step(200, 1);
    step(479, 0);
    step(480, 0);
    step(480, 1);
    w_pending = 1; w_slot = 3'd2; w_data = 18'h0ABC;
    step(480, 2);
    chk("coll_held", 32'(w_pending), 32'd1);
    step(480, 3);
    chk("coll_taken", 32'(w_pending), 32'd0);
    chk("coll_old", 32'(entity_5), 32'h3C00);
    step(500, 0);
    step(0, 0);
    vblank_commit();
    chk("coll_next", 32'(entity_5), 32'h0ABC);
    step(0, 0);

    // Illegal slot and last-write-wins.
    write(100, 3'd7, 18'h3FFFF);
    chk("illegal_err", 32'(wr_err), 32'd1);
    write(110, 3'd4, 18'h2ABCD);
    write(120, 3'd4, 18'h11111);
    vblank_commit();
    chk("last_wins", 32'(entity_7_Array), 32'h11111);
    chk("illegal_e1", 32'(entity_1), 32'h1234);
    step(0, 0);

    // Hold deferral and one dropped frame.
    run_frame(1);
    chk("defer_dropped", 32'(frames_dropped), 32'd0);
    run_frame(2);
    chk("drop_one", 32'(frames_dropped), 32'd1);

    // Randomized frames with random writes.
    wr_prob = 40;
    for (int f = 0; f < 40; f++) run_frame(int'($urandom_range(0, 3)));

    // Saturation.
    for (int f = 0; f < 300; f++) run_frame(2);
    chk("drop_sat", 32'(frames_dropped), 32'd255);

    // Reset during the COMMIT cycle leaves no partial copy.
    wr_prob = 0;
    step(0, 0);
    write(100, 3'd1, 18'h0555);
    step(479, 0);
    step(480, 0);
    step(480, 1);
    chk("rc_pulse", 32'(commit_pulse), 32'd1);
    do_reset(2);
    chk("rc_entity_4", 32'(entity_4), 32'h3C00);
    chk("rc_dropped", 32'(frames_dropped), 32'd0);
    step(100, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
